cpu_cycle_sequencer: RTL and testbench
======================================

# cpu_cycle_sequencer

Multi-cycle control sequencer for the 16-bit processor. It steps each instruction through fetch, decode, execute, memory and writeback phases on the single system clock `clk`. It drives one-cycle enable strobes to the PC, instruction register, ALU, register file and memory port, and it handshakes with a variable-latency memory. It sits between the clock generator and the datapath and is the only block that issues datapath strobes.

## Interface
Parameters:
- `MAX_WAIT`, 15: maximum memory wait cycles before the fault trap (range 1..255).
- `OPW`, 4: opcode width.

Ports:
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: level; leaves IDLE when high.
- `opcode` in OPW: IR opcode field; valid from DECODE onward.
- `mem_ready` in 1: memory completion, sampled while `mem_req` is high.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: write qualifier; only high together with `mem_req`.
- `ir_load` out 1: latch fetched word into IR.
- `alu_en` out 1: ALU operate strobe.
- `reg_we` out 1: register-file write strobe.
- `pc_inc` out 1: PC += 1 strobe.
- `pc_load` out 1: PC ← jump target strobe.
- `busy` out 1: high in every state except IDLE, HALT and FAULT.
- `halted` out 1: high in HALT.
- `fault` out 1: high in FAULT.
- `retired` out 16: count of completed instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT, FAULT.
- Opcode classes:
  - 0x0: NOP.
  - 0x1–0x7: ALU.
  - 0x8: LOAD.
  - 0x9: STORE.
  - 0xA: JMP.
  - 0xF: HLT.
  - 0xB–0xE: reserved, executed as NOP.
- IDLE → FETCH when `start`=1.
- FETCH: `mem_req`=1, `mem_we`=0 until `mem_ready`. `ir_load` pulses combinationally in the cycle `mem_ready`=1; next state is DECODE.
- DECODE: one cycle, no strobes → EXECUTE.
- EXECUTE: one cycle. Strobes and next state by class:
  - ALU: `alu_en`=1 → WRITEBACK.
  - LOAD/STORE: `alu_en`=1 (address generation) → MEMORY.
  - JMP: `pc_load`=1, retire → FETCH.
  - NOP/reserved: `pc_inc`=1, retire → FETCH.
  - HLT: retire → HALT.
- MEMORY: `mem_req`=1, with `mem_we`=1 for STORE. When `mem_ready` is seen:
  - LOAD → WRITEBACK.
  - STORE: `pc_inc`=1, retire → FETCH.
- WRITEBACK: one cycle; `reg_we`=1, `pc_inc`=1, retire → FETCH.
- Retire means `retired` increments on that edge. The counter wraps 0xFFFF → 0x0000.
- Wait counter: 8 bits, cleared on entry to FETCH/MEMORY, increments each cycle `mem_req`=1 and `mem_ready`=0. If it reaches `MAX_WAIT` with `mem_ready` still 0 → FAULT, with `mem_req` dropped the next cycle.
- HALT and FAULT are sticky; only `rst` exits them. `start` is ignored outside IDLE.
- `mem_ready` is ignored when `mem_req`=0.
- Reset, asynchronous and at any time including mid-handshake:
  - state = IDLE.
  - All strobes, `mem_req`, `mem_we`, `busy`, `halted`, `fault` = 0.
  - `retired` = 0; wait counter = 0.

## Timing
- Strobes are Moore/registered-state decodes, one cycle wide. The exception is `ir_load`, which is qualified by `mem_ready`.
- At most one of `pc_inc`/`pc_load` per cycle. `reg_we` and `alu_en` are never high in the same cycle.
- Latency with zero-wait memory (`mem_ready` high on first request cycle), from first FETCH cycle to retire:
  - NOP/JMP: 3 cycles.
  - ALU: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
- Each memory wait cycle adds one cycle.
- `start`=1 in IDLE: FETCH begins on the next edge; `busy` rises the same edge.
- FAULT entry: `mem_req` is high for exactly `MAX_WAIT`+1 cycles, counting from the request's first cycle.

## Structure
- Shared package `cpu_pkg` holds:
  - The state encoding (3-bit enum).
  - Opcode constants: OP_NOP, OP_LOAD, OP_STORE, OP_JMP, OP_HLT, and the ALU range bounds.
  - An opcode-class function.
- Natural sub-module: `mem_wait_timer`, the wait counter plus timeout compare. Ports: `clk`, `rst`, `clear`, `count_en`, `timeout`.
- The rest is one FSM process plus combinational strobe decode.

## Test plan
- Reset then `start`=1, opcode 0x3, zero-wait memory → `ir_load` at cycle 1, `alu_en` at cycle 3, `reg_we`+`pc_inc` at cycle 4, `retired`=1.
- LOAD (0x8) with `mem_ready` delayed 2 cycles in MEMORY → `mem_req` high 3 cycles with `mem_we`=0; `reg_we` one cycle after `mem_ready`; 7 cycles total.
- STORE (0x9) → `mem_we`=1 only in MEMORY; `pc_inc` in MEMORY completion cycle; no `reg_we`.
- JMP (0xA) then HLT (0xF) → `pc_load` once, no `pc_inc`; `halted`=1, `busy`=0; `retired`=2. `start` toggling afterward has no effect.
- `MAX_WAIT`=3, `mem_ready` held 0 in FETCH → `mem_req` high 4 cycles, then `fault`=1 and all strobes 0. Asserting `rst` mid-MEMORY clears everything asynchronously, before the next edge.

Source files
------------

// File: rtl/cpu_cycle_sequencer_pkg.sv
// cpu_pkg: shared definitions for the multi-cycle control sequencer.
//   state_t    - 3-bit FSM state encoding
//   op_class_t - decoded instruction class
//   OP_*       - opcode constants and the ALU opcode range
//   op_class() - maps a 4-bit opcode to its class
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6,
    S_FAULT     = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_NOP   = 3'd0,
    C_ALU   = 3'd1,
    C_LOAD  = 3'd2,
    C_STORE = 3'd3,
    C_JMP   = 3'd4,
    C_HLT   = 3'd5
  } op_class_t;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ALU_LO = 4'h1;
  localparam logic [3:0] OP_ALU_HI = 4'h7;
  localparam logic [3:0] OP_LOAD   = 4'h8;
  localparam logic [3:0] OP_STORE  = 4'h9;
  localparam logic [3:0] OP_JMP    = 4'hA;
  localparam logic [3:0] OP_HLT    = 4'hF;

  // Reserved opcodes (0xB-0xE) fall through to the NOP class.
  function automatic op_class_t op_class(input logic [3:0] op);
    op_class_t c;
    c = C_NOP;
    if (op >= OP_ALU_LO && op <= OP_ALU_HI) c = C_ALU;
    else if (op == OP_LOAD)                 c = C_LOAD;
    else if (op == OP_STORE)                c = C_STORE;
    else if (op == OP_JMP)                  c = C_JMP;
    else if (op == OP_HLT)                  c = C_HLT;
    return c;
  endfunction

endpackage

// File: rtl/cpu_cycle_sequencer_mem_wait_timer.sv
// mem_wait_timer: 8-bit memory wait counter with timeout compare.
//   clk      - system clock
//   rst      - asynchronous active-high reset
//   clear    - zero the counter (takes priority over count_en)
//   count_en - count one more wait cycle
//   timeout  - counter has reached MAX_WAIT
module mem_wait_timer #(
  parameter logic [7:0] MAX_WAIT = 8'd15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic timeout
);

  logic [7:0] count;

  // Counting stops at MAX_WAIT; the sequencer leaves for FAULT from there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               count <= 8'd0;
    else if (clear)                        count <= 8'd0;
    else if (count_en && !timeout)         count <= count + 8'd1;
  end

  assign timeout = (count == MAX_WAIT);

endmodule

// File: rtl/cpu_cycle_sequencer.sv
// cpu_cycle_sequencer: multi-cycle fetch/decode/execute/memory/writeback
// control sequencer for the 16-bit processor.
//   clk, rst          - clock, asynchronous active-high reset
//   start             - level; leaves IDLE when high
//   opcode            - IR opcode field, valid from DECODE onward
//   mem_ready         - memory completion, only looked at while mem_req=1
//   mem_req, mem_we   - memory request and write qualifier
//   ir_load, alu_en, reg_we, pc_inc, pc_load - one-cycle datapath strobes
//   busy, halted, fault - status
//   retired           - completed-instruction count (wraps)
//   state_dbg         - current FSM state, for observation only
//
// Handshake: a memory transfer completes in the cycle where mem_req and
// mem_ready are both high; mem_req stays high until then or until the wait
// budget runs out, and mem_ready is ignored whenever mem_req is low.
module cpu_cycle_sequencer
  import cpu_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int OPW      = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           mem_we,
  output logic           ir_load,
  output logic           alu_en,
  output logic           reg_we,
  output logic           pc_inc,
  output logic           pc_load,
  output logic           busy,
  output logic           halted,
  output logic           fault,
  output logic [15:0]    retired,
  output logic [2:0]     state_dbg
);

  state_t    state, next_state;
  op_class_t cls;
  logic      retire;
  logic      timeout;
  logic      wait_clear;
  logic      wait_count;

  // The class is decoded from the low four opcode bits.
  assign cls = op_class(opcode[3:0]);

  // Any completed (or absent) request zeroes the counter, so every FETCH
  // and MEMORY phase starts counting from zero.
  assign wait_clear = !mem_req || mem_ready;
  assign wait_count = mem_req && !mem_ready;

  mem_wait_timer #(
    .MAX_WAIT (8'(MAX_WAIT))
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (wait_clear),
    .count_en (wait_count),
    .timeout  (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      retired <= 16'd0;
    end else begin
      state <= next_state;
      if (retire) retired <= retired + 16'd1;
    end
  end

  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_load    = 1'b0;
    alu_en     = 1'b0;
    reg_we     = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;
    retire     = 1'b0;
    case (state)
      S_IDLE: if (start) next_state = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load    = 1'b1;
          next_state = S_DECODE;
        end else if (timeout) begin
          next_state = S_FAULT;
        end
      end
      S_DECODE: next_state = S_EXECUTE;
      S_EXECUTE: begin
        case (cls)
          C_ALU: begin
            alu_en     = 1'b1;
            next_state = S_WRITEBACK;
          end
          C_LOAD, C_STORE: begin
            alu_en     = 1'b1;  // address generation
            next_state = S_MEMORY;
          end
          C_JMP: begin
            pc_load    = 1'b1;
            retire     = 1'b1;
            next_state = S_FETCH;
          end
          C_HLT: begin
            retire     = 1'b1;
            next_state = S_HALT;
          end
          default: begin
            pc_inc     = 1'b1;
            retire     = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end
      S_MEMORY: begin
        mem_req = 1'b1;
        mem_we  = (cls == C_STORE);
        if (mem_ready) begin
          if (cls == C_STORE) begin
            pc_inc     = 1'b1;
            retire     = 1'b1;
            next_state = S_FETCH;
          end else begin
            next_state = S_WRITEBACK;
          end
        end else if (timeout) begin
          next_state = S_FAULT;
        end
      end
      S_WRITEBACK: begin
        reg_we     = 1'b1;
        pc_inc     = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: next_state = S_IDLE;
    endcase
  end

  assign busy      = (state != S_IDLE) && (state != S_HALT) && (state != S_FAULT);
  assign state_dbg = state;

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// Self-checking bench for cpu_cycle_sequencer (MAX_WAIT = 3).
// Each instruction is expanded from its class and chosen wait counts into a
// per-cycle list of expected outputs (strobes, status, retired count) plus
// the mem_ready/opcode values to drive; the list is then replayed cycle by
// cycle and compared.
module tb_cpu_cycle_sequencer;

  localparam int MW = 3;
  localparam int W  = 26;  // {retired[15:0], 10 output bits}

  localparam logic [9:0] REQ = 10'b10_0000_0000;
  localparam logic [9:0] WE  = 10'b01_0000_0000;
  localparam logic [9:0] IRL = 10'b00_1000_0000;
  localparam logic [9:0] ALU = 10'b00_0100_0000;
  localparam logic [9:0] REG = 10'b00_0010_0000;
  localparam logic [9:0] PCI = 10'b00_0001_0000;
  localparam logic [9:0] PCL = 10'b00_0000_1000;
  localparam logic [9:0] BSY = 10'b00_0000_0100;
  localparam logic [9:0] HLT = 10'b00_0000_0010;
  localparam logic [9:0] FLT = 10'b00_0000_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, ir_load, alu_en, reg_we, pc_inc, pc_load;
  logic        busy, halted, fault;
  logic [15:0] retired;
  logic [2:0]  state_dbg;

  cpu_cycle_sequencer #(.MAX_WAIT(MW), .OPW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .ir_load   (ir_load),
    .alu_en    (alu_en),
    .reg_we    (reg_we),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .busy      (busy),
    .halted    (halted),
    .fault     (fault),
    .retired   (retired),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic         rdy_q[$];
  logic [3:0]   op_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [15:0]  model_ret = 16'd0;

  function automatic logic [W-1:0] observed();
    return {retired, mem_req, mem_we, ir_load, alu_en, reg_we, pc_inc,
            pc_load, busy, halted, fault};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] expv);
    logic [W-1:0] obs;
    obs = observed();
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s obs=%h/%b exp=%h/%b", tag, obs[25:10], obs[9:0],
             expv[25:10], expv[9:0]);
    end
  endtask

  task automatic push(input logic [9:0] v, input logic rdy, input logic [3:0] op);
    exp_q.push_back({model_ret, v});
    rdy_q.push_back(rdy);
    op_q.push_back(op);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] rnd_op();
    return 4'($urandom_range(0, 15));
  endfunction

  // Expected per-cycle behaviour of one instruction, derived from its class.
  task automatic add_instr(input logic [3:0] op, input int fw, input int mw);
    bit is_store;
    is_store = (op == 4'h9);
    for (int i = 0; i < fw; i++) push(REQ | BSY, 1'b0, rnd_op());
    push(REQ | IRL | BSY, 1'b1, rnd_op());
    push(BSY, rnd_bit(), op);  // decode
    if (op >= 4'h1 && op <= 4'h7) begin
      push(ALU | BSY, rnd_bit(), op);
      push(REG | PCI | BSY, rnd_bit(), op);
      model_ret++;
    end else if (op == 4'h8 || is_store) begin
      push(ALU | BSY, rnd_bit(), op);
      for (int i = 0; i < mw; i++) push(REQ | BSY | (is_store ? WE : 10'd0), 1'b0, op);
      if (is_store) begin
        push(REQ | WE | PCI | BSY, 1'b1, op);
        model_ret++;
      end else begin
        push(REQ | BSY, 1'b1, op);
        push(REG | PCI | BSY, rnd_bit(), op);
        model_ret++;
      end
    end else if (op == 4'hA) begin
      push(PCL | BSY, rnd_bit(), op);
      model_ret++;
    end else if (op == 4'hF) begin
      push(BSY, rnd_bit(), op);
      model_ret++;
    end else begin
      push(PCI | BSY, rnd_bit(), op);
      model_ret++;
    end
  endtask

  task automatic add_idle_like(input logic [9:0] v, input int n);
    for (int i = 0; i < n; i++) push(v, rnd_bit(), rnd_op());
  endtask

  // ---------------- driver tasks ----------------
  task automatic play(input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      mem_ready = rdy_q.pop_front();
      opcode    = op_q.pop_front();
      start     = rnd_bit();
      #1;
      check($sformatf("%s_c%0d", tag, n), exp_q.pop_front());
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    mem_ready = 1'b1;
    #1;
    model_ret = 16'd0;
    check("reset", {16'd0, 10'd0});
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    mem_ready = rnd_bit();
    #1;
    check("idle", {model_ret, 10'd0});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // Directed: ALU, LOAD with 2 waits, STORE, JMP, HLT, then sticky HALT.
    do_reset();
    do_start();
    add_instr(4'h3, 0, 0);
    add_instr(4'h8, 0, 2);
    add_instr(4'h9, 1, 1);
    add_instr(4'hA, 0, 0);
    add_instr(4'hF, 0, 0);
    add_idle_like(HLT, 6);
    play("dir");

    // Random instruction stream with waits up to the budget edge.
    do_reset();
    do_start();
    for (int k = 0; k < 40; k++)
      add_instr(4'($urandom_range(0, 14)), $urandom_range(0, MW), $urandom_range(0, MW));
    add_instr(4'hF, $urandom_range(0, MW), 0);
    add_idle_like(HLT, 4);
    play("rnd");

    // Fetch never answered: MW+1 request cycles, then sticky FAULT.
    do_reset();
    do_start();
    for (int i = 0; i <= MW; i++) push(REQ | BSY, 1'b0, rnd_op());
    add_idle_like(FLT, 5);
    play("flt");

    // Asynchronous reset in the middle of a LOAD memory wait.
    do_reset();
    do_start();
    add_instr(4'h0, 1, 0);
    for (int i = 0; i < 2; i++) push(REQ | BSY, 1'b0, rnd_op());
    push(REQ | IRL | BSY, 1'b1, rnd_op());
    push(BSY, rnd_bit(), 4'h8);
    push(ALU | BSY, rnd_bit(), 4'h8);
    push(REQ | BSY, 1'b0, 4'h8);
    play("pre");
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("midmem", {16'd1, REQ | BSY});
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", {16'd0, 10'd0});
    @(negedge clk);
    rst = 1'b0;
    model_ret = 16'd0;
    start = 1'b0;
    #1;
    check("post_rst", {16'd0, 10'd0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
